uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10417, meaning clk cycles per serial bit (9600 bps at 100 MHz); legal range 2..131071.
REQ-002 The block SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port req0_valid  input  1  requester 0 has a byte to send.
REQ-005 The block SHALL have port req0_data  input  8  requester 0 byte.
REQ-006 The block SHALL have port req0_ready  output  1  requester 0 byte accepted this cycle when valid.
REQ-007 The block SHALL have ports req1_valid, req1_data, req1_ready with the same widths and meanings for requester 1.
REQ-008 The block SHALL have port txd  output  1  serial line, 8N1, idle high.
REQ-009 The block SHALL have port busy  output  1  frame in progress.
REQ-010 The block SHALL have port grant_id  output  1  requester whose byte is on txd (valid while busy).

Function
REQ-011 States SHALL be IDLE, START, DATA, STOP; IDLE->START on handshake, START->DATA after one bit time, DATA->STOP after 8 bit times, STOP->IDLE after one bit time.
REQ-012 A bit time SHALL be exactly CLKS_PER_BIT cycles, timed by a 17-bit counter cleared on each handshake and at each bit boundary, with a bit tick when the counter equals CLKS_PER_BIT-1.
REQ-013 req0_ready/req1_ready SHALL be combinational, asserted only in IDLE, at most one high, and only for the selected requester.
REQ-014 Selection: only one valid -> that one; both valid -> the one not granted last (round robin); neither -> ready held low.
REQ-015 A handshake (valid and ready high in the same cycle) SHALL capture data and requester index into registers; inputs are ignored at all other times.
REQ-016 txd SHALL go low on the cycle after the handshake, and busy SHALL rise on that same cycle.
REQ-017 Data bits SHALL be sent LSB first, then one stop bit (high).
REQ-018 After the stop bit, the block SHALL spend exactly one cycle in IDLE with txd high before the next start bit (minimum back-to-back spacing 10*CLKS_PER_BIT+1 cycles).
REQ-019 busy SHALL fall on the cycle the FSM re-enters IDLE.
REQ-020 Deasserting valid before ready is legal; no byte is lost or duplicated.
REQ-021 Each requester SHALL receive exactly one ready pulse per accepted byte.

Reset
REQ-022 Asserting rst SHALL immediately (asynchronously) set: state IDLE, txd 1, busy 0, grant_id 0, counters 0, last-grant = 1 (requester 0 wins first contention).
REQ-023 Reset mid-frame SHALL abandon the frame, with no completion or ready pulse generated for it.
REQ-024 req0_ready/req1_ready SHALL be 0 while rst is asserted.

Structure
REQ-025 A shared uart_pkg SHALL hold the FSM state encoding, the 8N1 frame constants (data bits 8, stop bits 1) and the default CLKS_PER_BIT.
REQ-026 Bit timing SHALL live in one sub-module, uart_bit_timer (parameter CLKS_PER_BIT; ports clk, rst, clear, tick).

Verification (CLKS_PER_BIT=4)
REQ-027 Single byte: req0 sends 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; start bit on the cycle after ready; grant_id=0.
REQ-028 Contention: both valid from reset with 0x11/0x22 -> order 0x11 (req0), 0x22 (req1), 0x11 again if req0 is still valid; 1 idle cycle between frames.
REQ-029 Withdrawal: req1_valid pulses during an req0 frame then drops -> no req1 ready and no frame for req1.
REQ-030 Reset mid-DATA (after bit 3) -> txd high and busy low asynchronously; after release, next req0 byte 0x3C is sent cleanly.
REQ-031 Continuous valid on req1 only with 0xFF -> frames start every 41 cycles; txd low for exactly 4 cycles per frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, 8N1 frame shape and default bit rate.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;
    localparam int DEFAULT_CLKS_PER_BIT = 10417;
    localparam int CNT_W                = 17;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-time counter; tick marks the last cycle of each bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end feeding a single 8N1 UART transmitter.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       txd,
    output logic       busy,
    output logic       grant_id
);

    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_t state;
    uart_state_t next_state;

    logic       last_grant;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       sel;
    logic       idle;
    logic       hs;
    logic       tick;

    assign idle = (state == ST_IDLE);

    // On contention the requester not served last wins.
    assign sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

    assign req0_ready = rst & idle & req0_valid & ~sel;
    assign req1_ready = rst & idle & req1_valid & sel;
    assign hs         = req0_ready | req1_ready;
    assign busy       = ~idle;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(hs),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (hs) next_state = ST_START;
            end
            ST_START: begin
                if (tick) next_state = ST_DATA;
            end
            ST_DATA: begin
                if (tick && bit_cnt == DATA_LAST) next_state = ST_STOP;
            end
            ST_STOP: begin
                if (tick && bit_cnt == STOP_LAST) next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        txd = 1'b1;
        unique case (state)
            ST_IDLE:  txd = 1'b1;
            ST_START: txd = 1'b0;
            ST_DATA:  txd = shreg[0];
            ST_STOP:  txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else if (hs) begin
            shreg      <= sel ? req1_data : req0_data;
            bit_cnt    <= '0;
            grant_id   <= sel;
            last_grant <= sel;
        end else if (tick) begin
            unique case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                end
                ST_START: begin
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= (bit_cnt == DATA_LAST) ? 3'd0 : bit_cnt + 3'd1;
                end
                ST_STOP: begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with CLKS_PER_BIT = 4.
module tb_uart_tx_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       txd;
    logic       busy;
    logic       grant_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n0 = 0;
    int n1 = 0;

    uart_tx_arbiter #(
        .CLKS_PER_BIT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .txd       (txd),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req0_valid && req0_ready) n0 <= n0 + 1;
        if (req1_valid && req1_ready) n1 <= n1 + 1;
    end

    typedef struct {
        logic rst;
        logic v0;
        logic v1;
        logic r0;
        logic r1;
        logic txd;
        logic busy;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_start(input string name, output int s);
        s = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                s = cyc;
                break;
            end
        end
        chk({name, "_start_seen"}, int'(s >= 0), 1);
    endtask

    // Caller sits on the first start-bit negedge; ends on the idle negedge.
    task automatic check_frame(input string name, input logic [7:0] b,
                               input logic g);
        logic [9:0] bits;
        logic [2:0] act;
        logic [2:0] exp;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            exp = {bits[i], 1'b1, g};
            act = exp;
            for (int k = 0; k < 4; k++) begin
                if (i > 0 || k > 0) @(negedge clk);
                if ({txd, busy, grant_id} !== exp && act === exp)
                    act = {txd, busy, grant_id};
            end
            chk($sformatf("%s_bit%0d", name, i), int'(act), int'(exp));
        end
        @(negedge clk);
        chk({name, "_idle_gap"}, int'({txd, busy}), 2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    int s1, s2, s3, c0, b0, b1, lows;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data = 8'h00;
        req1_data = 8'h00;
        #1;
        chk("reset_state", int'({txd, busy, grant_id}), 4);

        // Ready decode in IDLE; valids drop again before every edge.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            req0_valid = vecs[i].v0;
            req1_valid = vecs[i].v1;
            #1;
            chk($sformatf("vec%0d", i),
                int'({req0_ready, req1_ready, txd, busy}),
                int'({vecs[i].r0, vecs[i].r1, vecs[i].txd, vecs[i].busy}));
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;

        // Single byte from req0.
        @(negedge clk);
        b0 = n0;
        req0_data = 8'hA5;
        req0_valid = 1'b1;
        c0 = cyc;
        #1;
        chk("single_ready", int'({req0_ready, req1_ready}), 2);
        wait_start("single", s1);
        req0_valid = 1'b0;
        chk("single_latency", s1 - c0, 1);
        check_frame("single", 8'hA5, 1'b0);
        chk("single_pulses", n0 - b0, 1);

        // Contention from reset.
        do_reset();
        b0 = n0;
        b1 = n1;
        req0_data = 8'h11;
        req1_data = 8'h22;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_start("cont0", s1);
        check_frame("cont0", 8'h11, 1'b0);
        wait_start("cont1", s2);
        check_frame("cont1", 8'h22, 1'b1);
        wait_start("cont2", s3);
        check_frame("cont2", 8'h11, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("cont_gap01", s2 - s1, 41);
        chk("cont_gap12", s3 - s2, 41);
        chk("cont_pulses0", n0 - b0, 2);
        chk("cont_pulses1", n1 - b1, 1);

        // req1 pulses valid during a req0 frame and withdraws.
        @(negedge clk);
        b0 = n0;
        b1 = n1;
        req0_data = 8'h5A;
        req0_valid = 1'b1;
        wait_start("wd", s1);
        req0_valid = 1'b0;
        req1_data = 8'h99;
        req1_valid = 1'b1;
        fork
            check_frame("wd", 8'h5A, 1'b0);
            begin
                repeat (10) @(negedge clk);
                req1_valid = 1'b0;
            end
        join
        lows = 0;
        repeat (50) begin
            @(negedge clk);
            if (txd === 1'b0) lows++;
        end
        chk("wd_no_frame", lows, 0);
        chk("wd_pulses1", n1 - b1, 0);
        chk("wd_pulses0", n0 - b0, 1);

        // Reset in the middle of data bit 4.
        b0 = n0;
        req0_data = 8'hC3;
        req0_valid = 1'b1;
        wait_start("rst", s1);
        req0_valid = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b0;
        req0_valid = 1'b1;
        req0_data = 8'h3C;
        #1;
        chk("rst_async", int'({txd, busy, req0_ready}), 4);
        @(negedge clk);
        chk("rst_hold", int'({txd, busy, req0_ready}), 4);
        rst = 1'b1;
        wait_start("post_rst", s1);
        req0_valid = 1'b0;
        check_frame("post_rst", 8'h3C, 1'b0);
        chk("rst_pulses0", n0 - b0, 2);

        // Continuous req1 with 0xFF.
        b1 = n1;
        req1_data = 8'hFF;
        req1_valid = 1'b1;
        s2 = 0;
        for (int f = 0; f < 3; f++) begin
            wait_start($sformatf("ff%0d", f), s1);
            chk($sformatf("ff%0d_grant", f), int'(grant_id), 1);
            if (f > 0) chk($sformatf("ff%0d_gap", f), s1 - s2, 41);
            s2 = s1;
            lows = 0;
            while (txd === 1'b0 && lows < 10) begin
                lows++;
                @(negedge clk);
            end
            chk($sformatf("ff%0d_low", f), lows, 4);
        end
        req1_valid = 1'b0;
        chk("ff_pulses1", n1 - b1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
